fifo_push_arbiter: RTL and testbench
====================================

Name: fifo_push_arbiter

Overview:
- Shares the write port of one fifo instance among NREQ producers.
- Arbitration is round-robin with burst locking: a granted producer keeps the write port for up to BURST transfers, then ownership rotates.
- Drives the fifo push/datain pair directly and observes fifo full.
- Instantiated in front of the fifo; it is the only push source for that fifo.

Parameters:
- NREQ, 4, number of producers (≥2).
- BUSW, 32, data width; must equal the fifo busw.
- BURST, 4, maximum transfers per grant (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-low reset; one clock; polarity and synchronicity fixed.
- req_valid  in  NREQ  producer i has a word on req_data[i].
- req_data  in  NREQ×BUSW  packed producer data; slice i is producer i.
- req_ready  out  NREQ  one-hot or zero; transfer for i = req_valid[i] && req_ready[i].
- fifo_full  in  1  fifo full flag.
- fifo_push  out  1  push strobe to fifo.
- fifo_datain  out  BUSW  data to fifo.
- grant_valid  out  1  high while in LOCK.
- grant_id  out  IDW  current owner; IDW = $clog2(NREQ).
- burst_done  out  1  one-cycle pulse on the cycle the BURST-th transfer of a grant occurs.

Behaviour:
- Reset (rst low, async):
  - state=IDLE, owner=0, rr_ptr=0, cnt=0.
  - All outputs 0; fifo_datain=0.
  - A reset mid-burst abandons the burst; no push is issued in the reset cycle.
- State IDLE:
  - No ready, no push.
  - If any req_valid: winner = first set bit searching from rr_ptr upward, wrapping NREQ-1→0.
  - Next cycle: LOCK, owner=winner, cnt=0.
  - Grant latency from first valid in IDLE is 1 cycle.
- State LOCK (all combinational):
  - req_ready[owner] = !fifo_full.
  - fifo_push = req_valid[owner] && !fifo_full.
  - fifo_datain = req_data[owner]; 0 when not in LOCK.
  - grant_valid = 1, grant_id = owner.
- Transfer in LOCK: cnt = cnt+1.
  - cnt width $clog2(BURST+1); cnt never exceeds BURST-1 at a clock edge.
- Release conditions, evaluated each LOCK cycle:
  - (a) a transfer occurs with cnt==BURST-1: burst_done=1 that cycle.
  - (b) req_valid[owner]==0: voluntary release; no transfer that cycle.
- On release:
  - rr_ptr = (owner+1) mod NREQ.
  - Re-arbitrate in the same cycle from the new rr_ptr using the current req_valid.
  - If a winner exists: stay in LOCK with the new owner, cnt=0. No bubble; a back-to-back burst from a different producer can start the next cycle.
  - Otherwise go to IDLE.
  - On release (a), the former owner is eligible but has lowest priority.
- fifo_full in LOCK:
  - No transfer; cnt and owner hold.
  - No timeout: the lock persists until data drains or the owner drops valid.
- Invariants:
  - fifo_push never asserts while fifo_full=1.
  - At most one req_ready bit is set.
  - Non-owners never see ready.
  - Data order per producer is preserved.
- Producers may drop valid without a transfer; this is legal and triggers release (b).
- Changing req_data[owner] while valid is high and ready is low is allowed; the value sampled is the one present in the transfer cycle.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_e {IDLE, LOCK}.
  - Function idw(n) returning max(1, $clog2(n)).
- Sub-module rr_pick:
  - Parameter NREQ.
  - Inputs req[NREQ], ptr[IDW]; outputs any, winner[IDW].
  - Purely combinational rotate/priority-encode/unrotate.
  - Instantiated once and shared by the IDLE and release paths.

Test Plan:
- Reset then req_valid=4'b0001 held, data 0x10..0x13, BURST=4, fifo never full:
  - grant_id=0 one cycle after valid.
  - Four pushes 0x10–0x13 on consecutive cycles.
  - burst_done on the 4th push.
  - Re-grant to 0 with no bubble.
- All four producers valid continuously:
  - Grants rotate 0,1,2,3,0 with 4 pushes each.
  - No idle cycles between bursts.
  - 16 pushes in 16 cycles after first grant.
- Owner 2 drops valid after 2 transfers while producer 3 is valid:
  - Release that cycle; grant_id=3 next cycle.
  - Producer 2 is not served again before 3.
- fifo_full asserted for 5 cycles mid-burst, owner 1, cnt=2:
  - No push, no ready, grant_id=1 holds.
  - After full drops, the remaining 2 transfers complete, then burst_done.
- rst pulsed low mid-burst:
  - Outputs 0 immediately (async).
  - After release, with only producer 3 valid: grant_id=3, and rr_ptr restarts from 0.
- Random valid/full stress for 10k cycles with per-producer scoreboard:
  - No push while full.
  - No word lost or reordered.
  - No producer waits more than (NREQ-1)·BURST transfers of others.

Source files
------------

// File: rtl/fifo_push_arbiter_pkg.sv
// rtl/fifo_push_arbiter_pkg.sv - shared types and helpers for the fifo push arbiter
// Contents: arb_state_e (IDLE/LOCK) and idw(n), the index width for n producers.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Index width for n producers; never below 1 so single-bit ids still exist.
    function automatic int idw(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_push_arbiter_if.sv
// rtl/fifo_push_arbiter_if.sv - producer and fifo write-port bundle for the arbiter
// Signals:
//   req_valid/req_data/req_ready : NREQ producer handshakes, data packed slice i = producer i
//   fifo_full/fifo_push/fifo_datain : fifo write port
// Modports: master = producers + fifo side, slave = arbiter side.
interface fifo_push_arbiter_if #(
    parameter int NREQ = 4,
    parameter int BUSW = 32
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*BUSW-1:0] req_data;
    logic [NREQ-1:0]      req_ready;
    logic                 fifo_full;
    logic                 fifo_push;
    logic [BUSW-1:0]      fifo_datain;

    modport master (
        output req_valid,
        output req_data,
        output fifo_full,
        input  req_ready,
        input  fifo_push,
        input  fifo_datain
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  fifo_full,
        output req_ready,
        output fifo_push,
        output fifo_datain
    );
endinterface

// File: rtl/fifo_push_arbiter_rr_pick.sv
// rtl/fifo_push_arbiter_rr_pick.sv - combinational round-robin picker
// Ports:
//   req    in  NREQ  request vector
//   ptr    in  IDW   highest-priority index
//   any    out 1     at least one request set
//   winner out IDW   first set request searching from ptr upward, wrapping
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ = 4,
    localparam int IDW  = idw(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic            any,
    output logic [IDW-1:0]  winner
);

    logic [NREQ-1:0] rot;
    int              off;
    int              sum;

    always_comb begin
        // Rotate so ptr lands at bit 0; the doubled vector handles the wrap.
        rot = NREQ'({req, req} >> ptr);
        any = |req;

        // Lowest set bit of the rotated vector is the offset from ptr.
        off = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = i;
            end
        end

        // Undo the rotation modulo NREQ (NREQ need not be a power of two).
        sum = int'(ptr) + off;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        winner = IDW'(sum);
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// rtl/fifo_push_arbiter.sv - round-robin, burst-locked sharing of one fifo write port
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset
//   bus          slave producer handshakes and fifo write port
//   grant_valid  out  a producer owns the write port
//   grant_id     out  current owner (0 when no grant)
//   burst_done   out  pulse on the BURST-th transfer of a grant
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NREQ  = 4,
    parameter  int BUSW  = 32,
    parameter  int BURST = 4,
    localparam int IDW   = idw(NREQ),
    localparam int CW    = $clog2(BURST + 1)
) (
    input  logic                clk,
    input  logic                rst,
    fifo_push_arbiter_if.slave  bus,
    output logic                grant_valid,
    output logic [IDW-1:0]      grant_id,
    output logic                burst_done
);

    arb_state_e     state;
    logic [IDW-1:0] owner;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  cnt;

    logic           in_lock;
    logic           owner_valid;
    logic           xfer;
    logic           last_xfer;
    logic           rel;
    logic [IDW-1:0] next_ptr;
    logic [IDW-1:0] pick_ptr;
    logic           any;
    logic [IDW-1:0] winner;

    always_comb begin
        in_lock     = (state == LOCK);
        owner_valid = bus.req_valid[owner];
        xfer        = in_lock && owner_valid && !bus.fifo_full;
        last_xfer   = xfer && (cnt == CW'(BURST - 1));
        // Either the burst is used up or the owner walked away.
        rel         = in_lock && (last_xfer || !owner_valid);
        next_ptr    = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
        // On release the picker searches from just past the owner, so the
        // former owner is considered last; otherwise from the saved pointer.
        pick_ptr    = rel ? next_ptr : rr_ptr;
    end

    // Single picker shared by the IDLE grant and the same-cycle re-grant.
    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req    (bus.req_valid),
        .ptr    (pick_ptr),
        .any    (any),
        .winner (winner)
    );

    always_comb begin
        bus.req_ready = '0;
        if (in_lock && !bus.fifo_full) begin
            bus.req_ready[owner] = 1'b1;
        end
        bus.fifo_push   = xfer;
        bus.fifo_datain = in_lock ? bus.req_data[int'(owner)*BUSW +: BUSW] : '0;
        grant_valid     = in_lock;
        grant_id        = in_lock ? owner : '0;
        burst_done      = last_xfer;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state <= LOCK;
                        owner <= winner;
                        cnt   <= '0;
                    end
                end
                LOCK: begin
                    if (rel) begin
                        rr_ptr <= next_ptr;
                        cnt    <= '0;
                        if (any) begin
                            owner <= winner;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb/tb_fifo_push_arbiter.sv - self-checking bench for fifo_push_arbiter
module tb_fifo_push_arbiter;
    localparam int NREQ  = 4;
    localparam int BUSW  = 32;
    localparam int BURST = 4;
    localparam int IDW   = fifo_arb_pkg::idw(NREQ);

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           burst_done;

    fifo_push_arbiter_if #(.NREQ(NREQ), .BUSW(BUSW)) bus ();

    fifo_push_arbiter #(
        .NREQ  (NREQ),
        .BUSW  (BUSW),
        .BURST (BURST)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .burst_done  (burst_done)
    );

    always #5 clk = ~clk;

    int              errors = 0;
    int              checks = 0;
    logic [BUSW-1:0] pdata [NREQ];

    typedef struct {
        logic [NREQ-1:0] valid;
        logic            full;
        logic [BUSW-1:0] d0;
        logic            gv;
        int              gid;
        logic [NREQ-1:0] ready;
        logic            push;
        logic            bd;
        logic [BUSW-1:0] dout;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic gv, input int gid,
                              input logic [NREQ-1:0] rdy, input logic push,
                              input logic bd, input logic [BUSW-1:0] dout);
        chk({tag, "_grant_valid"}, 64'(grant_valid), 64'(gv));
        chk({tag, "_grant_id"}, 64'(grant_id), 64'(gid));
        chk({tag, "_req_ready"}, 64'(bus.req_ready), 64'(rdy));
        chk({tag, "_fifo_push"}, 64'(bus.fifo_push), 64'(push));
        chk({tag, "_burst_done"}, 64'(burst_done), 64'(bd));
        chk({tag, "_fifo_datain"}, 64'(bus.fifo_datain), 64'(dout));
    endtask

    task automatic drive(input logic [NREQ-1:0] v, input logic f);
        bus.req_valid = v;
        bus.fifo_full = f;
        for (int i = 0; i < NREQ; i++) begin
            bus.req_data[i*BUSW +: BUSW] = pdata[i];
        end
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = '0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
    endtask

    task automatic set_data(input int base);
        for (int i = 0; i < NREQ; i++) begin
            pdata[i] = BUSW'(base + i);
        end
    endtask

    // Producer 2 completes one burst (pointer moves to 3) and is re-granted;
    // reset hits during that second burst.
    task automatic burst_then_reset(input string tag);
        reset_dut();
        set_data(32'h500);
        drive(4'b0100, 1'b0);
        tick();
        for (int k = 0; k < BURST; k++) begin
            drive(4'b0100, 1'b0);
            tick();
        end
        drive(4'b0100, 1'b0);
        expect_out({tag, "_pre"}, 1'b1, 2, 4'b0100, 1'b1, 1'b0, 32'h502);
        rst = 1'b0;
        #1;
        expect_out({tag, "_async"}, 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();
        expect_out({tag, "_held"}, 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        #1;
    endtask

    // Reference model state: owner index or -1, transfers in this grant, search start.
    int m_owner;
    int m_cnt;
    int m_ptr;

    function automatic int pick(input logic [NREQ-1:0] v, input int from);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(from + k) % NREQ]) begin
                return (from + k) % NREQ;
            end
        end
        return -1;
    endfunction

    initial begin
        // Reset state
        bus.req_valid = '0;
        bus.fifo_full = 1'b0;
        bus.req_data  = '0;
        #2;
        expect_out("reset", 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0);

        // Single producer, four-word burst then no-bubble re-grant and release
        tbl[0] = '{4'b0001, 1'b0, 32'h10, 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0};
        tbl[1] = '{4'b0001, 1'b0, 32'h10, 1'b1, 0, 4'b0001, 1'b1, 1'b0, 32'h10};
        tbl[2] = '{4'b0001, 1'b0, 32'h11, 1'b1, 0, 4'b0001, 1'b1, 1'b0, 32'h11};
        tbl[3] = '{4'b0001, 1'b0, 32'h12, 1'b1, 0, 4'b0001, 1'b1, 1'b0, 32'h12};
        tbl[4] = '{4'b0001, 1'b0, 32'h13, 1'b1, 0, 4'b0001, 1'b1, 1'b1, 32'h13};
        tbl[5] = '{4'b0001, 1'b0, 32'h14, 1'b1, 0, 4'b0001, 1'b1, 1'b0, 32'h14};
        tbl[6] = '{4'b0000, 1'b0, 32'h15, 1'b1, 0, 4'b0001, 1'b0, 1'b0, 32'h15};
        tbl[7] = '{4'b0000, 1'b0, 32'h16, 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0};
        reset_dut();
        set_data(32'hA0);
        for (int r = 0; r < 8; r++) begin
            pdata[0] = tbl[r].d0;
            drive(tbl[r].valid, tbl[r].full);
            expect_out($sformatf("tbl%0d", r), tbl[r].gv, tbl[r].gid, tbl[r].ready,
                       tbl[r].push, tbl[r].bd, tbl[r].dout);
            tick();
        end

        // All producers valid: rotating bursts, no idle cycles
        reset_dut();
        for (int k = 0; k < 21; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                pdata[i] = BUSW'(32'h2000 + (i << 8) + k);
            end
            drive(4'b1111, 1'b0);
            if (k == 0) begin
                expect_out("all_c0", 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0);
            end else begin
                int g;
                g = ((k - 1) / BURST) % NREQ;
                expect_out($sformatf("all_c%0d", k), 1'b1, g, NREQ'(1 << g), 1'b1,
                           ((k - 1) % BURST) == BURST - 1, pdata[g]);
            end
            tick();
        end

        // Owner 2 drops after two transfers while producer 3 waits
        reset_dut();
        set_data(32'h300);
        drive(4'b0100, 1'b0);
        expect_out("drop_c0", 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();
        for (int k = 1; k <= 2; k++) begin
            drive(4'b1100, 1'b0);
            expect_out($sformatf("drop_c%0d", k), 1'b1, 2, 4'b0100, 1'b1, 1'b0, 32'h302);
            tick();
        end
        drive(4'b1000, 1'b0);
        expect_out("drop_c3", 1'b1, 2, 4'b0100, 1'b0, 1'b0, 32'h302);
        tick();
        for (int k = 0; k < BURST; k++) begin
            drive(4'b1100, 1'b0);
            expect_out($sformatf("drop_p3_%0d", k), 1'b1, 3, 4'b1000, 1'b1,
                       k == BURST - 1, 32'h303);
            tick();
        end
        drive(4'b1100, 1'b0);
        expect_out("drop_back2", 1'b1, 2, 4'b0100, 1'b1, 1'b0, 32'h302);
        tick();

        // fifo_full for five cycles with owner 1 at cnt=2
        reset_dut();
        set_data(32'h400);
        drive(4'b0010, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(4'b0010, 1'b0);
            expect_out($sformatf("full_pre%0d", k), 1'b1, 1, 4'b0010, 1'b1, 1'b0, 32'h401);
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            drive(4'b0010, 1'b1);
            expect_out($sformatf("full_hold%0d", k), 1'b1, 1, 4'b0000, 1'b0, 1'b0, 32'h401);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(4'b0010, 1'b0);
            expect_out($sformatf("full_post%0d", k), 1'b1, 1, 4'b0010, 1'b1, k == 1, 32'h401);
            tick();
        end

        // Reset mid-burst, then only producer 3 valid
        burst_then_reset("rsta");
        drive(4'b1000, 1'b0);
        expect_out("rsta_idle", 1'b0, 0, 4'b0000, 1'b0, 1'b0, 32'h0);
        tick();
        drive(4'b1000, 1'b0);
        expect_out("rsta_g3", 1'b1, 3, 4'b1000, 1'b1, 1'b0, 32'h503);
        tick();

        // Reset mid-burst with pointer at 3: search must restart at 0
        burst_then_reset("rstb");
        drive(4'b1010, 1'b0);
        tick();
        drive(4'b1010, 1'b0);
        expect_out("rstb_ptr0", 1'b1, 1, 4'b0010, 1'b1, 1'b0, 32'h501);
        tick();

        // Randomized stress against the reference model and scoreboard
        begin
            logic [NREQ-1:0] v;
            logic            f;
            int              tx_seq [NREQ];
            int              rx_seq [NREQ];
            int              wt [NREQ];
            bit              xf [NREQ];
            int              max_wait;
            logic            e_gv;
            int              e_gid;
            logic [NREQ-1:0] e_ready;
            logic            e_push;
            logic            e_bd;
            logic [BUSW-1:0] e_dout;
            int              p;
            int              w;

            reset_dut();
            m_owner  = -1;
            m_cnt    = 0;
            m_ptr    = 0;
            max_wait = 0;
            v        = '0;
            f        = 1'b0;
            for (int i = 0; i < NREQ; i++) begin
                tx_seq[i] = 0;
                rx_seq[i] = 0;
                wt[i]     = 0;
            end

            for (int c = 0; c < 10000; c++) begin
                for (int i = 0; i < NREQ; i++) begin
                    pdata[i] = {8'(i), 24'(tx_seq[i])};
                end
                drive(v, f);

                e_gv    = (m_owner >= 0);
                e_gid   = e_gv ? m_owner : 0;
                e_ready = '0;
                e_push  = 1'b0;
                e_dout  = '0;
                if (e_gv) begin
                    if (!f) e_ready[m_owner] = 1'b1;
                    e_push = v[m_owner] && !f;
                    e_dout = pdata[m_owner];
                end
                e_bd = e_push && (m_cnt == BURST - 1);
                expect_out("rnd", e_gv, e_gid, e_ready, e_push, e_bd, e_dout);

                if (bus.fifo_push) begin
                    p = int'(bus.fifo_datain[31:24]);
                    if (p < NREQ) begin
                        chk("sb_order", 64'(bus.fifo_datain), 64'({8'(p), 24'(rx_seq[p])}));
                        rx_seq[p]++;
                    end else begin
                        chk("sb_id", 64'(p), 64'(0));
                    end
                end

                for (int i = 0; i < NREQ; i++) begin
                    xf[i] = v[i] && bus.req_ready[i];
                    if (xf[i]) tx_seq[i]++;
                end

                // Transfers by others while producer i keeps waiting ungranted
                for (int i = 0; i < NREQ; i++) begin
                    if (!v[i] || (e_gv && m_owner == i)) begin
                        wt[i] = 0;
                    end else if (e_push) begin
                        wt[i]++;
                        if (wt[i] > max_wait) max_wait = wt[i];
                    end
                end

                if (!e_gv) begin
                    w = pick(v, m_ptr);
                    if (w >= 0) begin
                        m_owner = w;
                        m_cnt   = 0;
                    end
                end else if (!v[m_owner] || e_bd) begin
                    m_ptr   = (m_owner + 1) % NREQ;
                    m_owner = pick(v, m_ptr);
                    m_cnt   = 0;
                end else if (e_push) begin
                    m_cnt++;
                end

                tick();

                for (int i = 0; i < NREQ; i++) begin
                    if (xf[i]) begin
                        v[i] = ($urandom_range(0, 4) != 0);
                    end else if (v[i]) begin
                        v[i] = ($urandom_range(0, 15) != 0);
                    end else begin
                        v[i] = ($urandom_range(0, 1) != 0);
                    end
                end
                f = ($urandom_range(0, 3) == 0);
            end

            for (int i = 0; i < NREQ; i++) begin
                chk($sformatf("sb_count%0d", i), 64'(rx_seq[i]), 64'(tx_seq[i]));
            end
            chk("max_wait_bound", 64'(max_wait <= (NREQ - 1) * BURST), 64'(1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
